// File: rtl/uart_pkg.sv
// Shared types and default sizing for the buffered Uart8 transmit front-end.
//   txFifoState_t : transmit sequencer states
//   DEPTH_DEF     : default FIFO depth (power of two, >= 2)
//   WIDTH_DEF     : Uart8 byte width
package uart_pkg;

  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } txFifoState_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous circular-buffer FIFO with sticky overflow flag.
//   clk, rst        : clock, async active-high reset
//   wrEn, wrData    : push strobe and data
//   rdEn            : pop strobe (ignored when empty)
//   clrErr          : clears overflow (a same-cycle drop wins)
//   rdData_c        : head entry, combinational
//   full, empty     : occupancy flags, registered
//   count           : stored entries, registered
//   overflow        : sticky, set when a push is dropped
module byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wrEn,
  input  logic [WIDTH-1:0]           wrData,
  input  logic                       rdEn,
  input  logic                       clrErr,
  output logic [WIDTH-1:0]           rdData_c,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wrPtr;
  logic [PtrW-1:0]  rdPtr;
  logic             push;
  logic             pop;
  logic             drop;
  logic [CntW-1:0]  cntNext;

  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  always_comb begin
    pop     = rdEn & ~empty;
    push    = wrEn & (~full | pop);
    drop    = wrEn & ~push;
    cntNext = count + CntW'(push) - CntW'(pop);
  end

  assign rdData_c = mem[rdPtr];

  // Storage has no reset; only pointers and flags need defined values.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PtrW'(1);
      if (pop)  rdPtr <= rdPtr + PtrW'(1);
      count <= cntNext;
      full  <= (cntNext == CntW'(DEPTH));
      empty <= (cntNext == '0);
      if (drop)        overflow <= 1'b1;
      else if (clrErr) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered transmit front-end for Uart8: queues host bytes and sequences one
// Uart8 frame per byte from txBusy/txDone feedback.
//   clk, rst                 : clock, async active-high reset
//   en                       : block enable, mirrored on txEn
//   wrEn, wrData             : host push port
//   clrErr                   : clears overflow
//   full, empty, count       : FIFO status (count excludes the byte in flight)
//   overflow                 : sticky dropped-push flag
//   busy                     : sequencer not idle
//   txEn, txStart, txIn      : to Uart8
//   txBusy, txDone           : from Uart8
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       wrEn,
  input  logic [WIDTH-1:0]           wrData,
  input  logic                       clrErr,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       busy,
  output logic                       txEn,
  output logic                       txStart,
  output logic [WIDTH-1:0]           txIn,
  input  logic                       txBusy,
  input  logic                       txDone
);

  txFifoState_t     state;
  txFifoState_t     stateNext;
  logic             popC;
  logic             txDoneQ;
  logic [WIDTH-1:0] headC;

  byte_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .wrEn     (wrEn),
    .wrData   (wrData),
    .rdEn     (popC),
    .clrErr   (clrErr),
    .rdData_c (headC),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  // Sequencer next-state; dropping en abandons the frame but keeps the queue.
  always_comb begin
    stateNext = state;
    popC      = 1'b0;
    case (state)
      IDLE: begin
        if (en && !empty) begin
          popC      = 1'b1;
          stateNext = START;
        end
      end
      START: begin
        if (!en)        stateNext = IDLE;
        else if (txBusy) stateNext = SEND;
      end
      SEND: begin
        if (!en)                    stateNext = IDLE;
        else if (txDone && !txDoneQ) stateNext = GAP;
      end
      GAP: begin
        if (!en || !txBusy) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and registered outputs; txStart/busy follow the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      txDoneQ <= 1'b0;
      txEn    <= 1'b0;
      txStart <= 1'b0;
      busy    <= 1'b0;
      txIn    <= '0;
    end else begin
      state   <= stateNext;
      txDoneQ <= txDone;
      txEn    <= en;
      txStart <= (stateNext == START);
      busy    <= (stateNext != IDLE);
      if (popC) txIn <= headC;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small Uart8 peer model and a manual
// txBusy/txDone driver for corner cases.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             wrEn;
  logic [WIDTH-1:0] wrData;
  logic             clrErr;
  logic             full;
  logic             empty;
  logic [4:0]       count;
  logic             overflow;
  logic             busy;
  logic             txEn;
  logic             txStart;
  logic [WIDTH-1:0] txIn;
  logic             txBusy;
  logic             txDone;

  logic             peerOn;
  logic             peerBusy;
  logic             peerDone;
  logic [2:0]       peerCnt;
  logic             manBusy;
  logic             manDone;
  logic [7:0]       rxQ [$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign txBusy = peerOn ? peerBusy : manBusy;
  assign txDone = peerOn ? peerDone : manDone;

  uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .wrEn     (wrEn),
    .wrData   (wrData),
    .clrErr   (clrErr),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .txEn     (txEn),
    .txStart  (txStart),
    .txIn     (txIn),
    .txBusy   (txBusy),
    .txDone   (txDone)
  );

  // Uart8 peer: latch txIn on txStart, stay busy a few cycles, pulse done.
  always @(posedge clk) begin
    if (!peerOn) begin
      peerBusy <= 1'b0;
      peerDone <= 1'b0;
      peerCnt  <= 3'd0;
    end else begin
      peerDone <= 1'b0;
      if (!peerBusy) begin
        if (txStart) begin
          peerBusy <= 1'b1;
          peerCnt  <= 3'd3;
          rxQ.push_back(txIn);
        end
      end else if (peerCnt != 3'd0) begin
        peerCnt <= peerCnt - 3'd1;
      end else begin
        peerBusy <= 1'b0;
        peerDone <= 1'b1;
      end
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushByte(input logic [7:0] d);
    wrData = d;
    wrEn   = 1'b1;
    tick();
    wrEn   = 1'b0;
  endtask

  task automatic doReset();
    rst     = 1'b1;
    peerOn  = 1'b0;
    en      = 1'b0;
    wrEn    = 1'b0;
    wrData  = '0;
    clrErr  = 1'b0;
    manBusy = 1'b0;
    manDone = 1'b0;
    tick();
    rst = 1'b0;
    rxQ.delete();
    tick();
  endtask

  task automatic waitStart(input string tag, input int budget);
    int k = 0;
    while (txStart !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    checkVal(tag, 32'(txStart), 32'd1);
  endtask

  task automatic waitDrain(input string tag, input int n, input int budget);
    int k = 0;
    while (!(rxQ.size() == n && empty && !busy) && k < budget) begin
      tick();
      k++;
    end
    checkVal(tag, 32'(rxQ.size()), 32'(n));
  endtask

  initial begin
    logic [7:0] seq1 [3];
    bit         bseq [5];
    seq1 = '{8'h1E, 8'h18, 8'h13};
    bseq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset values
    rst = 1'b1; peerOn = 1'b0; en = 1'b0; wrEn = 1'b0; wrData = '0;
    clrErr = 1'b0; manBusy = 1'b0; manDone = 1'b0;
    tick(2);
    checkVal("rst_txStart", 32'(txStart), 32'd0);
    checkVal("rst_txEn", 32'(txEn), 32'd0);
    checkVal("rst_txIn", 32'(txIn), 32'd0);
    checkVal("rst_count", 32'(count), 32'd0);
    checkVal("rst_empty", 32'(empty), 32'd1);
    checkVal("rst_full", 32'(full), 32'd0);
    checkVal("rst_overflow", 32'(overflow), 32'd0);
    checkVal("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Three bytes through the peer, in order
    peerOn = 1'b1;
    en     = 1'b1;
    for (int i = 0; i < 3; i++) pushByte(seq1[i]);
    waitDrain("t1_rx_count", 3, 300);
    for (int i = 0; i < 3; i++)
      if (i < rxQ.size()) checkVal($sformatf("t1_rx%0d", i), 32'(rxQ[i]), 32'(seq1[i]));
    checkVal("t1_empty", 32'(empty), 32'd1);
    checkVal("t1_busy", 32'(busy), 32'd0);
    checkVal("t1_txEn", 32'(txEn), 32'd1);

    // Overfill with en=0: 17th byte dropped
    doReset();
    checkVal("t2_push_latency_empty", 32'(empty), 32'd1);
    pushByte(8'h00);
    checkVal("t2_push_latency_count", 32'(count), 32'd1);
    for (int i = 1; i < 17; i++) pushByte(8'(i));
    checkVal("t2_count", 32'(count), 32'd16);
    checkVal("t2_full", 32'(full), 32'd1);
    checkVal("t2_overflow", 32'(overflow), 32'd1);
    clrErr = 1'b1;
    tick();
    clrErr = 1'b0;
    checkVal("t2_clrErr", 32'(overflow), 32'd0);

    // Push while full on the popping cycle is accepted
    peerOn = 1'b1;
    en     = 1'b1;
    pushByte(8'h55);
    checkVal("t3_count", 32'(count), 32'd16);
    checkVal("t3_overflow", 32'(overflow), 32'd0);
    checkVal("t3_txStart", 32'(txStart), 32'd1);
    checkVal("t3_txIn", 32'(txIn), 32'h00);
    waitDrain("t3_rx_count", 17, 1500);
    if (rxQ.size() == 17) begin
      for (int i = 0; i < 16; i++)
        checkVal($sformatf("t3_rx%0d", i), 32'(rxQ[i]), 32'(i));
      checkVal("t3_rx16", 32'(rxQ[16]), 32'h55);
    end

    // Long txDone pulse completes exactly one frame
    doReset();
    pushByte(8'hA1);
    pushByte(8'hA2);
    pushByte(8'hA3);
    en = 1'b1;
    waitStart("t4_start", 5);
    checkVal("t4_count_pop", 32'(count), 32'd2);
    checkVal("t4_txIn_a1", 32'(txIn), 32'hA1);
    manBusy = 1'b1;
    tick();
    checkVal("t4_send_txStart", 32'(txStart), 32'd0);
    for (int i = 0; i < 5; i++) begin
      manDone = 1'b1;
      manBusy = bseq[i];
      tick();
    end
    manDone = 1'b0;
    manBusy = 1'b0;
    tick(3);
    checkVal("t4_count_once", 32'(count), 32'd1);
    checkVal("t4_txIn_a2", 32'(txIn), 32'hA2);
    checkVal("t4_busy", 32'(busy), 32'd1);
    checkVal("t4_txStart", 32'(txStart), 32'd0);

    // Dropping en during SEND abandons the byte but keeps the queue
    doReset();
    pushByte(8'h5B);
    pushByte(8'h11);
    pushByte(8'h22);
    pushByte(8'h33);
    checkVal("t5_count4", 32'(count), 32'd4);
    en = 1'b1;
    waitStart("t5_start", 5);
    checkVal("t5_txIn_5b", 32'(txIn), 32'h5B);
    checkVal("t5_count3", 32'(count), 32'd3);
    manBusy = 1'b1;
    tick();
    checkVal("t5_send_busy", 32'(busy), 32'd1);
    en = 1'b0;
    tick();
    checkVal("t5_idle_busy", 32'(busy), 32'd0);
    checkVal("t5_idle_txStart", 32'(txStart), 32'd0);
    checkVal("t5_retained", 32'(count), 32'd3);
    checkVal("t5_txEn", 32'(txEn), 32'd0);
    manBusy = 1'b0;
    rxQ.delete();
    peerOn = 1'b1;
    en     = 1'b1;
    begin
      int k = 0;
      while (rxQ.size() == 0 && k < 100) begin
        tick();
        k++;
      end
    end
    checkVal("t5_rx_count", 32'(rxQ.size()), 32'd1);
    if (rxQ.size() > 0) checkVal("t5_next_byte", 32'(rxQ[0]), 32'h11);
    checkVal("t5_count2", 32'(count), 32'd2);

    // Asynchronous reset while in START
    doReset();
    pushByte(8'h77);
    pushByte(8'h88);
    en = 1'b1;
    waitStart("t6_start", 5);
    #2 rst = 1'b1;
    #1;
    checkVal("t6_txStart", 32'(txStart), 32'd0);
    checkVal("t6_txEn", 32'(txEn), 32'd0);
    checkVal("t6_txIn", 32'(txIn), 32'd0);
    checkVal("t6_count", 32'(count), 32'd0);
    checkVal("t6_empty", 32'(empty), 32'd1);
    checkVal("t6_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    en  = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered transmit front-end for the `Uart8` transmitter: accepts bytes from a host-side write port into a DEPTH-entry FIFO and drives the Uart8 `txEn`/`txStart`/`txIn` inputs, sequencing one frame per byte from Uart8's `txBusy`/`txDone` feedback. It sits directly upstream of the Uart8 TX interface. With it in place, the producer no longer has to pace bytes against frame timing.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `WIDTH`, 8, data width; fixed to Uart8 byte width
- `clk`  in  1  system clock, the same clock as Uart8 `clk`
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  block enable; drives `txEn`
- `wrEn`  in  1  push strobe, one byte per cycle
- `wrData`  in  WIDTH  byte to push
- `clrErr`  in  1  clears `overflow`
- `full`  out  1  FIFO holds DEPTH bytes
- `empty`  out  1  FIFO holds 0 bytes
- `count`  out  $clog2(DEPTH+1)  bytes stored (excludes byte in flight)
- `overflow`  out  1  sticky: a push was dropped
- `busy`  out  1  FSM not in IDLE
- `txEn`  out  1  to Uart8 `txEn`
- `txStart`  out  1  to Uart8 `txStart`
- `txIn`  out  WIDTH  to Uart8 `txIn`, stable while frame outstanding
- `txBusy`  in  1  from Uart8 `txBusy`
- `txDone`  in  1  from Uart8 `txDone`

## Operation
- FIFO: circular buffer, read/write pointers of $clog2(DEPTH) bits wrap modulo DEPTH; `count` tracks occupancy.
- Push with `full`=0 is stored. Push with `full`=1 and a same-cycle pop is stored. Push with `full`=1 and no pop is dropped and sets `overflow`.
- `clrErr` clears `overflow`. When `clrErr` and a dropped push coincide, set wins.
- `txEn` = `en` (registered).
- The FSM has four states:
  - IDLE: if `en` and not `empty`, pop the head into the `txIn` register, then go to START.
  - START: `txStart`=1. When `txBusy`=1 is sampled, go to SEND.
  - SEND: `txStart`=0. On the rising edge of `txDone` (`txDone` & ~`txDone_q`), go to GAP.
  - GAP: wait for `txBusy`=0, then go to IDLE.
- `txDone` is edge-detected with one register, so a multi-cycle `txDone` pulse counts as one completion.
- `en` deasserted in any non-IDLE state: next cycle the FSM returns to IDLE with `txStart`=0. The in-flight byte is discarded and FIFO contents are retained.
- Async `rst` mid-frame: all state is cleared immediately and `txStart` drops. Uart8 is not reset by this block.

## Timing
- Reset values:
  - `txStart`=0, `txEn`=0, `txIn`=0
  - `count`=0, `empty`=1, `full`=0
  - `overflow`=0, `busy`=0, `txDone_q`=0
  - FSM in IDLE
- Push latency: `count`/`empty` update the cycle after `wrEn`.
- Byte available in IDLE → `txStart`=1 and `txIn` valid after 1 cycle. The pop is visible in `count` on the same edge.
- `txStart` stays high until `txBusy` is observed; there is no timeout.
- Back-to-back frames: IDLE→START the cycle after GAP exits, so minimum overhead is 2 `clk` cycles plus Uart8 latency.
- Simultaneous push and pop at `empty`=1 cannot occur, because the pop requires a stored byte. The new byte is popped on a later IDLE cycle.
- `txIn` changes only on the IDLE→START transition.

## Structure
- Package `uart_pkg`: FSM state enum `txFifoState_t` {IDLE, START, SEND, GAP} and the default DEPTH/WIDTH constants.
- Sub-module `byte_fifo`: the synchronous FIFO (storage, pointers, count, full/empty, overflow). The top level holds the FSM, the `txDone` edge detect and the output registers.

## Test plan
- Reset then push 0x1E, 0x18, 0x13 with Uart8 attached and `en`=1 → the Uart8 peer receives 0x1E, 0x18, 0x13 in order; `empty`=1 and `busy`=0 at the end.
- Push 17 bytes (DEPTH=16) in consecutive cycles while `en`=0 → `count`=16, `full`=1, `overflow`=1, byte 17 lost. Then `clrErr` → `overflow`=0.
- Full FIFO with `en`=1: push on the cycle IDLE pops → push accepted, `count` stays 16, `overflow`=0.
- Hold `txDone` high for 5 cycles using a stub Uart8 → exactly one byte completes and `count` decrements once.
- Deassert `en` during SEND of 0x5B (4 bytes queued) → `txStart`=0 and IDLE next cycle; `count`=3 retained. Re-enable → the next byte (not 0x5B) is sent.
- Assert `rst` in START → outputs take reset values within the same cycle and `count`=0.
